// File: rtl/bcd_time_counter.sv
// BCD time-of-day counter: 24 h internal hh:mm:ss advanced by a prescaled 1 s tick,
// with validated loads, a day-wrap pulse and a registered 12/24 h display stage.
module bcd_time_counter #(
  parameter int unsigned CLK_DIV    = 50_000_000,
  parameter logic [7:0]  RESET_HOUR = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  input  logic       set_valid,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  output logic       set_ack,
  output logic       set_err,
  output logic [7:0] hour_out,
  output logic       pm,
  output logic [7:0] min_out,
  output logic [7:0] sec_out,
  output logic       tick_1s,
  output logic       day_wrap
);

  localparam int unsigned   PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic nib_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Goes through a binary hour so 22/23 come out as BCD 10/11 rather than 0A/0B.
  function automatic logic [7:0] to_12h(input logic [7:0] h);
    logic [4:0] dec;
    logic [7:0] r;
    dec = ({1'b0, h[7:4]} * 5'd10) + {1'b0, h[3:0]};
    if (dec == 5'd0)       dec = 5'd12;
    else if (dec > 5'd12)  dec = dec - 5'd12;
    if (dec >= 5'd10) r = {4'd1, 4'(dec - 5'd10)};
    else              r = {4'd0, dec[3:0]};
    return r;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hour_q, hour_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    sec_q, sec_d;

  logic [7:0]    hour_out_q, hour_out_d;
  logic          pm_q, pm_d;
  logic [7:0]    min_out_q, min_out_d;
  logic [7:0]    sec_out_q, sec_out_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;

  logic          tick;
  logic          set_legal;

  always_comb begin
    tick      = en && (presc_q == PRESC_MAX);
    set_legal = nib_ok(set_hour) && nib_ok(set_min) && nib_ok(set_sec) &&
                (set_hour <= 8'h23) && (set_min <= 8'h59) && (set_sec <= 8'h59);

    presc_d = presc_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    if (en) presc_d = tick ? '0 : presc_q + PW'(1);

    if (tick) begin
      tick_d = 1'b1;
      if (sec_q == 8'h59) begin
        sec_d = 8'h00;
        if (min_q == 8'h59) begin
          min_d = 8'h00;
          if (hour_q == 8'h23) begin
            hour_d = 8'h00;
            wrap_d = 1'b1;
          end else begin
            hour_d = bcd_inc(hour_q);
          end
        end else begin
          min_d = bcd_inc(min_q);
        end
      end else begin
        sec_d = bcd_inc(sec_q);
      end
    end

    // A legal load overrides any tick in the same cycle and restarts the second.
    if (set_valid) begin
      if (set_legal) begin
        hour_d  = set_hour;
        min_d   = set_min;
        sec_d   = set_sec;
        presc_d = '0;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        ack_d   = 1'b1;
      end else begin
        err_d   = 1'b1;
      end
    end

    // Display registers take the next state so pulses and the new time line up.
    hour_out_d = mode ? to_12h(hour_d) : hour_d;
    pm_d       = (hour_d >= 8'h12);
    min_out_d  = min_d;
    sec_out_d  = sec_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= '0;
      hour_q     <= RESET_HOUR;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
      hour_out_q <= 8'h00;
      pm_q       <= 1'b0;
      min_out_q  <= 8'h00;
      sec_out_q  <= 8'h00;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      hour_out_q <= hour_out_d;
      pm_q       <= pm_d;
      min_out_q  <= min_out_d;
      sec_out_q  <= sec_out_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign hour_out = hour_out_q;
  assign pm       = pm_q;
  assign min_out  = min_out_q;
  assign sec_out  = sec_out_q;
  assign tick_1s  = tick_q;
  assign day_wrap = wrap_q;
  assign set_ack  = ack_q;
  assign set_err  = err_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: directed scenarios plus random traffic, checked against
// a seconds-of-day reference model.
module tb_bcd_time_counter;
  localparam int         CLK_DIV    = 4;
  localparam logic [7:0] RESET_HOUR = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, en = 1'b0, mode = 1'b0, set_valid = 1'b0;
  logic [7:0] set_hour = 8'h00, set_min = 8'h00, set_sec = 8'h00;
  logic       set_ack, set_err, pm, tick_1s, day_wrap;
  logic [7:0] hour_out, min_out, sec_out;

  bcd_time_counter #(.CLK_DIV(CLK_DIV), .RESET_HOUR(RESET_HOUR)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .set_valid(set_valid),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .set_ack(set_ack), .set_err(set_err), .hour_out(hour_out), .pm(pm),
    .min_out(min_out), .sec_out(sec_out), .tick_1s(tick_1s), .day_wrap(day_wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: time as seconds since midnight, prescaler as a phase count.
  int         m_secs  = 0;
  int         m_phase = 0;
  logic [7:0] e_hour = 8'h00, e_min = 8'h00, e_sec = 8'h00;
  logic       e_pm = 1'b0, e_tick = 1'b0, e_wrap = 1'b0, e_ack = 1'b0, e_err = 1'b0;

  logic [28:0] dut_vec, exp_vec;
  assign dut_vec = {hour_out, pm, min_out, sec_out, tick_1s, day_wrap, set_ack, set_err};
  assign exp_vec = {e_hour, e_pm, e_min, e_sec, e_tick, e_wrap, e_ack, e_err};

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  function automatic int bcd_val(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit field_ok(input logic [7:0] v, input int max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (bcd_val(v) <= max);
  endfunction

  task automatic model_step();
    bit tk;
    int h;
    if (!rst_n) begin
      m_secs  = bcd_val(RESET_HOUR) * 3600;
      m_phase = 0;
      {e_hour, e_pm, e_min, e_sec, e_tick, e_wrap, e_ack, e_err} = '0;
    end else begin
      tk = en && (m_phase == CLK_DIV - 1);
      if (en) m_phase = tk ? 0 : m_phase + 1;
      e_tick = 0; e_wrap = 0; e_ack = 0; e_err = 0;
      if (set_valid && field_ok(set_hour, 23) && field_ok(set_min, 59) && field_ok(set_sec, 59)) begin
        m_secs  = bcd_val(set_hour) * 3600 + bcd_val(set_min) * 60 + bcd_val(set_sec);
        m_phase = 0;
        e_ack   = 1;
      end else begin
        if (set_valid) e_err = 1;
        if (tk) begin
          m_secs = (m_secs + 1) % 86400;
          e_tick = 1;
          e_wrap = (m_secs == 0);
        end
      end
      h      = m_secs / 3600;
      e_hour = mode ? to_bcd((h % 12 == 0) ? 12 : h % 12) : to_bcd(h);
      e_pm   = (h >= 12);
      e_min  = to_bcd((m_secs / 60) % 60);
      e_sec  = to_bcd(m_secs % 60);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    int ticks;
    mode = 1; rst_n = 0; en = 0; set_valid = 0;
    repeat (3) begin
      cycle();
      n_checks++;
      if (dut_vec !== '0) $display("FAIL reset_zero: got %h want 0", dut_vec);
      else n_pass++;
    end
    rst_n = 1;
    cycle();
    n_checks++;
    if (hour_out !== 8'h12 || pm !== 1'b0 || dut_vec !== exp_vec)
      $display("FAIL reset_release: got %h want %h (hour 12)", dut_vec, exp_vec);
    else n_pass++;
    en = 1; ticks = 0;
    repeat (12) begin
      cycle();
      ticks += int'(tick_1s);
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL prescale_run: got %h want %h", dut_vec, exp_vec);
      else n_pass++;
    end
    n_checks++;
    if (ticks != 3) $display("FAIL tick_count_en: got %0d want 3", ticks);
    else n_pass++;
    en = 0; ticks = 0;
    repeat (8) begin
      cycle();
      ticks += int'(tick_1s);
    end
    n_checks++;
    if (ticks != 0 || dut_vec !== exp_vec) $display("FAIL tick_hold_dis: got %0d ticks want 0", ticks);
    else n_pass++;
  endtask

  task automatic test_day_wrap();
    int nt, cyc;
    mode = 0; en = 1;
    set_hour = 8'h23; set_min = 8'h59; set_sec = 8'h58; set_valid = 1;
    cycle();
    set_valid = 0;
    n_checks++;
    if (set_ack !== 1'b1 || sec_out !== 8'h58 || pm !== 1'b1 || dut_vec !== exp_vec)
      $display("FAIL wrap_load: got %h want %h", dut_vec, exp_vec);
    else n_pass++;
    nt = 0; cyc = 0;
    while (nt < 2 && cyc < 4 * CLK_DIV) begin
      cycle();
      cyc++;
      if (tick_1s === 1'b1) nt++;
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL wrap_run: got %h want %h", dut_vec, exp_vec);
      else n_pass++;
    end
    n_checks++;
    if (nt != 2 || {hour_out, min_out, sec_out} !== 24'h0 || day_wrap !== 1'b1 || pm !== 1'b0)
      $display("FAIL day_wrap: got ticks=%0d t=%h:%h:%h wrap=%b pm=%b want 2 00:00:00 1 0",
               nt, hour_out, min_out, sec_out, day_wrap, pm);
    else n_pass++;
    cycle();
    n_checks++;
    if (day_wrap !== 1'b0) $display("FAIL wrap_pulse_len: got %b want 0", day_wrap);
    else n_pass++;
  endtask

  task automatic test_hour_loop();
    int h12;
    mode = 1; en = 0; set_min = 8'h00; set_sec = 8'h00;
    for (int h = 0; h < 24; h++) begin
      set_hour = to_bcd(h); set_valid = 1;
      cycle();
      set_valid = 0;
      h12 = (h % 12 == 0) ? 12 : h % 12;
      n_checks++;
      if (hour_out !== to_bcd(h12) || pm !== (h >= 12) || set_ack !== 1'b1 || dut_vec !== exp_vec)
        $display("FAIL hour12_%0d: got hour=%h pm=%b want hour=%h pm=%b", h, hour_out, pm, to_bcd(h12), h >= 12);
      else n_pass++;
    end
    mode = 0;
    cycle();
    n_checks++;
    if (hour_out !== 8'h23 || min_out !== 8'h00) $display("FAIL mode_to_24: got %h want 23", hour_out);
    else n_pass++;
    mode = 1;
    cycle();
    n_checks++;
    if (hour_out !== 8'h11 || pm !== 1'b1) $display("FAIL mode_to_12: got %h want 11", hour_out);
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic [23:0] bad [5];
    bad[0] = {8'h24, 8'h00, 8'h00};
    bad[1] = {8'h00, 8'h60, 8'h00};
    bad[2] = {8'h00, 8'h00, 8'h1A};
    bad[3] = {8'h1F, 8'h10, 8'h10};
    bad[4] = {8'h12, 8'hA5, 8'h00};
    mode = 0; en = 1;
    set_hour = 8'h12; set_min = 8'h34; set_sec = 8'h56; set_valid = 1;
    cycle();
    set_valid = 0;
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 3)) cycle();
      {set_hour, set_min, set_sec} = bad[i]; set_valid = 1;
      cycle();
      set_valid = 0;
      n_checks++;
      if (set_err !== 1'b1 || set_ack !== 1'b0 || dut_vec !== exp_vec)
        $display("FAIL illegal_%0d: got %h want %h", i, dut_vec, exp_vec);
      else n_pass++;
    end
    repeat (2 * CLK_DIV) begin
      cycle();
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL illegal_phase: got %h want %h", dut_vec, exp_vec);
      else n_pass++;
    end
  endtask

  task automatic test_load_on_tick();
    int w, cnt;
    mode = 0; en = 1; w = 0;
    while (m_phase != CLK_DIV - 1 && w < 2 * CLK_DIV) begin
      cycle();
      w++;
    end
    n_checks++;
    if (m_phase != CLK_DIV - 1) $display("FAIL tick_align_timeout: got phase %0d want %0d", m_phase, CLK_DIV - 1);
    else n_pass++;
    set_hour = 8'h10; set_min = 8'h20; set_sec = 8'h30; set_valid = 1;
    cycle();
    set_valid = 0;
    n_checks++;
    if ({hour_out, min_out, sec_out} !== 24'h102030 || tick_1s !== 1'b0 || set_ack !== 1'b1)
      $display("FAIL load_on_tick: got %h:%h:%h tick=%b ack=%b want 10:20:30 0 1",
               hour_out, min_out, sec_out, tick_1s, set_ack);
    else n_pass++;
    cnt = 0;
    do begin
      cycle();
      cnt++;
    end while (tick_1s !== 1'b1 && cnt < 3 * CLK_DIV);
    n_checks++;
    if (cnt != CLK_DIV || sec_out !== 8'h31 || dut_vec !== exp_vec)
      $display("FAIL period_after_load: got %0d cycles sec=%h want %0d sec=31", cnt, sec_out, CLK_DIV);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    mode = 0; en = 1;
    set_hour = 8'h05; set_min = 8'h59; set_sec = 8'h59; set_valid = 1;
    cycle();
    set_valid = 0;
    repeat (2) cycle();
    rst_n = 0; set_hour = 8'h07; set_min = 8'h00; set_sec = 8'h00; set_valid = 1;
    cycle();
    set_valid = 0;
    n_checks++;
    if (dut_vec !== '0) $display("FAIL reset_mid: got %h want 0", dut_vec);
    else n_pass++;
    cycle();
    rst_n = 1;
    cycle();
    n_checks++;
    if ({hour_out, min_out, sec_out} !== {RESET_HOUR, 16'h0000} || set_ack !== 1'b0 ||
        set_err !== 1'b0 || day_wrap !== 1'b0 || dut_vec !== exp_vec)
      $display("FAIL reset_mid_release: got %h want %h", dut_vec, exp_vec);
    else n_pass++;
    repeat (2 * CLK_DIV) begin
      cycle();
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL reset_mid_run: got %h want %h", dut_vec, exp_vec);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    repeat (400) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      set_valid = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0: begin
          set_hour = to_bcd($urandom_range(0, 23));
          set_min  = to_bcd($urandom_range(0, 59));
          set_sec  = to_bcd($urandom_range(0, 59));
        end
        1: begin
          set_hour = 8'h23; set_min = 8'h59;
          set_sec  = to_bcd($urandom_range(55, 59));
        end
        default: begin
          set_hour = 8'($urandom); set_min = 8'($urandom); set_sec = 8'($urandom);
        end
      endcase
      cycle();
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL random: got %h want %h", dut_vec, exp_vec);
      else n_pass++;
    end
    set_valid = 0;
  endtask

  initial begin
    test_reset();
    test_day_wrap();
    test_hour_loop();
    test_illegal();
    test_load_on_tick();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
